// File: rtl/byte_stream_pkg.sv
// Shared byte-stream types for the FIFO and the downstream two-cycle delay stage.
package byte_stream_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

endpackage : byte_stream_pkg

// File: rtl/byte_fifo_if.sv
// Producer/consumer handshake bundle for byte_fifo; signal names are from the FIFO's point of view.
interface byte_fifo_if #(
    parameter int unsigned WIDTH = byte_stream_pkg::BYTE_W
);

    logic             in_valid_i;
    logic [WIDTH-1:0] in_data_i;
    logic             in_ready_o;
    logic             out_valid_o;
    logic [WIDTH-1:0] out_data_o;
    logic             out_ready_i;

    // Producer and consumer side, driven by whoever feeds and drains the FIFO.
    modport master (
        output in_valid_i,
        output in_data_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_data_o
    );

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output out_data_o
    );

endinterface : byte_fifo_if

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO with valid/ready handshakes, occupancy readout
// and a sticky flag for producers that change data while stalled.
module byte_fifo
    import byte_stream_pkg::*;
#(
    parameter int unsigned WIDTH = BYTE_W,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    byte_fifo_if.slave    bus,
    output logic [CW-1:0] count_o,
    output logic          err_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;
    logic             stall_q, stall_d;
    logic [WIDTH-1:0] data_q;

    logic push;
    logic pop;
    logic full;
    logic empty;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Ready depends only on registered count, so a pop cannot open a slot in the same cycle.
    assign bus.in_ready_o  = ~full;
    assign bus.out_valid_o = ~empty;
    assign bus.out_data_o  = mem_q[rd_q];
    assign count_o         = count_q;
    assign err_o           = err_q;

    assign push = bus.in_valid_i & ~full;
    assign pop  = bus.out_ready_i & ~empty;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        stall_d = bus.in_valid_i & full;
        err_d   = err_q | (stall_d & stall_q & (bus.in_data_i != data_q));

        if (flush_i) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wr_d = wr_q + 1'b1;
            end
            if (pop) begin
                rd_d = rd_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            stall_q <= 1'b0;
            data_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            err_q   <= err_d;
            stall_q <= stall_d;
            data_q  <= bus.in_data_i;
            if (push && !flush_i) begin
                mem_q[wr_q] <= bus.in_data_i;
            end
        end
    end

endmodule : byte_fifo

// File: tb/tb_byte_fifo.sv
// Self-checking bench for byte_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_byte_fifo;
    import byte_stream_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [2:0] count;
    logic       err;

    int unsigned n_total;
    int unsigned n_bad;

    byte_t q[$];
    bit    err_m;
    bit    pstall_m;
    byte_t pdata_m;

    byte_fifo_if #(.WIDTH(BYTE_W)) bus ();

    byte_fifo #(
        .WIDTH(BYTE_W),
        .DEPTH(DEPTH)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .flush_i(flush),
        .bus    (bus),
        .count_o(count),
        .err_o  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("count", count, q.size());
        chk("out_valid", bus.out_valid_o, (q.size() != 0) ? 1 : 0);
        chk("in_ready", bus.in_ready_o, (q.size() != DEPTH) ? 1 : 0);
        chk("err", err, err_m);
        if (q.size() != 0) chk("out_data", bus.out_data_o, q[0]);
    endtask

    // Called at a falling edge: check outputs, apply inputs, advance model one clock.
    task automatic step(input bit r, input bit f, input bit iv, input byte_t d, input bit ordy);
        bit full_m;
        bit stall;
        bit push;
        bit pop;
        check_model();
        rst               = r;
        flush             = f;
        bus.in_valid_i    = iv;
        bus.in_data_i     = d;
        bus.out_ready_i   = ordy;
        if (r) begin
            q.delete();
            err_m    = 1'b0;
            pstall_m = 1'b0;
            pdata_m  = '0;
        end else begin
            full_m = (q.size() == DEPTH);
            stall  = iv && full_m;
            if (stall && pstall_m && (d != pdata_m)) err_m = 1'b1;
            pstall_m = stall;
            pdata_m  = d;
            push = iv && !full_m;
            pop  = ordy && (q.size() != 0);
            if (f) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back(d);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        n_total         = 0;
        n_bad           = 0;
        rst             = 1'b1;
        flush           = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b0;
        err_m           = 1'b0;
        pstall_m        = 1'b0;
        pdata_m         = '0;
        @(posedge clk);
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        chk("rst_count", count, 0);
        chk("rst_valid", bus.out_valid_o, 0);
        chk("rst_ready", bus.in_ready_o, 1);
        chk("rst_err", err, 0);
        chk("rst_data", bus.out_data_o, 0);

        // Single write becomes visible one cycle later.
        step(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);
        chk("fwft_valid", bus.out_valid_o, 1);
        chk("fwft_data", bus.out_data_o, 8'hA5);
        chk("fwft_count", count, 1);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Fill, refuse a fifth, drain in order.
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 1'b1, byte_t'(i), 1'b0);
        chk("full_count", count, 4);
        chk("full_ready", bus.in_ready_o, 0);
        step(1'b0, 1'b0, 1'b1, 8'h05, 1'b0);
        chk("fifth_refused", count, 4);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_data", bus.out_data_o, i);
            step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        end
        chk("drained_valid", bus.out_valid_o, 0);
        chk("drained_count", count, 0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("empty_pop_count", count, 0);

        // Full with simultaneous pop: push refused, accepted the next cycle.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, byte_t'(8'h31 + i), 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h55, 1'b1);
        chk("full_pop_count", count, 3);
        step(1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
        chk("late_push_count", count, 4);
        for (int i = 0; i < 3; i++) begin
            chk("after_full_data", bus.out_data_o, 8'h32 + i);
            step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        end
        chk("late_push_data", bus.out_data_o, 8'h55);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Streaming: one byte per cycle, occupancy stays at one.
        for (int i = 8'h10; i <= 8'h1F; i++) begin
            step(1'b0, 1'b0, 1'b1, byte_t'(i), 1'b1);
            chk("stream_data", bus.out_data_o, i);
            chk("stream_count", count, 1);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Flush wins over a concurrent push.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, byte_t'(8'h61 + i), 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h77, 1'b1);
        chk("flush_count", count, 0);
        chk("flush_valid", bus.out_valid_o, 0);
        chk("flush_ready", bus.in_ready_o, 1);
        idle();
        chk("flush_no77", bus.out_valid_o, 0);

        // Data changing under backpressure sets the sticky error.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, byte_t'(8'h40 + i), 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h20, 1'b0);
        chk("stable_noerr", err, 0);
        step(1'b0, 1'b0, 1'b1, 8'h21, 1'b0);
        chk("err_set", err, 1);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("err_after_flush", err, 1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("err_after_rst", err, 0);

        // Random traffic; producer usually holds data while stalled.
        for (int n = 0; n < 3000; n++) begin
            bit    r;
            bit    f;
            bit    iv;
            bit    ordy;
            byte_t d;
            r    = ($urandom_range(0, 299) == 0);
            f    = ($urandom_range(0, 39) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            d    = byte_t'($urandom);
            if (pstall_m && ($urandom_range(0, 19) != 0)) d = pdata_m;
            step(r, f, iv, d, ordy);
        end
        check_model();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_byte_fifo
